csa_acc_4_2: RTL and testbench
==============================

Name: csa_acc_4_2

Overview:
Sequential redundant accumulator built on the 4:2 carry-save compressor datapath.
- Each accepted beat compresses the stored carry-save pair (ws, wc), optionally doubled, with one incoming carry-save operand (x_s, x_c) plus two carry-ins.
- No carry propagation occurs on the accumulation path.
- Serves as the residual/partial-product accumulator for online (MSDF) multipliers and dividers.
- Generalises the combinational compressor with a configurable term count, a shift-accumulate mode and valid/ready handshakes.

Parameters:
- WIDTH, 16, datapath width of operands and stored ws/wc.
- TRUNCATED_WIDTH, 16, number of active MSBs. LAST_INDEX = WIDTH-TRUNCATED_WIDTH; bits below LAST_INDEX are not computed.
- N_TERMS, 8, beats accumulated per operation (>=1).
- CNT_W, $clog2(N_TERMS+1), width of term_cnt.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; clears accumulator and begins a new operation
- mode_shift  in  1  sampled at start; 1 = state doubled before each add (w <= 2w + x), 0 = plain add
- in_valid  in  1  operand beat valid
- in_ready  out  1  accumulator accepts a beat
- x_s  in  WIDTH  operand sum vector
- x_c  in  WIDTH  operand carry vector
- cin1  in  1  carry-in injected at weight 2^LAST_INDEX
- cin2  in  1  second carry-in, same weight
- out_valid  out  1  final ws/wc available
- out_ready  in  1  consumer accepts result
- ws  out  WIDTH  registered redundant sum
- wc  out  WIDTH  registered redundant carry (same weight alignment as ws)
- term_cnt  out  CNT_W  beats accepted in the current operation
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; ws=0, wc=0, term_cnt=0, in_ready=0, out_valid=0, busy=0, mode register=0.
- FSM states: IDLE, ACCUM, HOLD (RESOLVE added by the optional feature).
- IDLE:
  - start=1 -> ACCUM next cycle; ws, wc and term_cnt cleared; mode_shift latched.
  - in_ready=0, so a beat presented in the same cycle as start is not taken.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - On acceptance, with V(a,b) = (a+b) mod 2^WIDTH and k = 2 if the latched mode is shift, else 1:
    V(ws',wc') = (k*V(ws,wc) + x_s + x_c + (cin1+cin2)*2^LAST_INDEX) mod 2^WIDTH.
  - The doubling is a left shift by 1 of both ws and wc; bits shifted out above WIDTH-1 are discarded.
  - Realised as one 4:2 compression per beat; the internal carry chain is confined to a single compressor level (two carry pipes).
  - term_cnt increments per accepted beat.
  - The N_TERMS-th acceptance -> HOLD.
  - No acceptance: ws, wc and term_cnt hold.
- Truncation: bits [LAST_INDEX-1:0] of ws and wc are forced to 0 at all times; the corresponding bits of x_s and x_c are ignored.
- HOLD:
  - out_valid=1, in_ready=0; ws and wc stable.
  - out_ready=1 -> IDLE next cycle; ws and wc retain their value in IDLE until the next start.
- start in ACCUM or HOLD: aborts the operation; same clear/latch as from IDLE; goes to ACCUM. Any beat or out_ready in that cycle is ignored.
- Latency: result valid 1 cycle after the final accepted beat. Throughput: 1 beat/cycle in ACCUM.
- Overflow wraps modulo 2^WIDTH; no saturation and no flag.
- Reset asserted mid-operation: immediate return to reset values; no partial result is presented.

Optional Feature:
Macro CSA_ACC_RESOLVE_EN.
- Defined:
  - Adds output port result [WIDTH-1:0] = (ws + wc) mod 2^WIDTH, a carry-propagate sum.
  - Inserts a RESOLVE state between ACCUM and HOLD (1 cycle), so out_valid rises 2 cycles after the last beat.
  - result resets to 0 and is held with ws/wc.
- Undefined: no result port, no RESOLVE state; latency as above.

Test Plan:
1. WIDTH=16, N_TERMS=4, mode_shift=0; four beats x_s=1, x_c=2, cin=0 -> out_valid 1 cycle after the 4th beat, (ws+wc) mod 2^16 = 12, term_cnt=4.
2. mode_shift=1; beats x_s=1, x_c=0, cin1=cin2=0 for 4 beats -> (ws+wc) mod 2^16 = 15. Repeat with cin1=cin2=1 on every beat -> 45.
3. Wrap-around: mode 0, N_TERMS=2; beats (x_s=16'hFFFF, x_c=16'h0001) then (16'h8000, 16'h8000) -> (ws+wc) mod 2^16 = 0.
4. Handshake: in_valid toggled 1,0,0,1,1,0,1 and out_ready held 0 for 3 cycles in HOLD -> only valid cycles counted, result stable while out_valid=1, IDLE after out_ready; start with in_valid in IDLE -> beat not counted.
5. TRUNCATED_WIDTH=12, mode 0; beat x_s=16'h00FF, x_c=0, cin1=1 -> ws/wc low 4 bits 0, (ws+wc) = 16'h00F0 + 16'h0010 = 16'h0100.
6. rst_n pulsed low mid-ACCUM after 2 beats -> all outputs 0 asynchronously, IDLE. start mid-HOLD -> ACCUM with term_cnt=0, ws=wc=0. With CSA_ACC_RESOLVE_EN, scenario 1 -> result=12, 2-cycle latency.

Source files
------------

// File: rtl/csa_acc_4_2.sv
// Redundant carry-save accumulator: one 4:2 compression per accepted beat.
// Optional CSA_ACC_RESOLVE_EN adds a resolved result port and a RESOLVE state.
module csa_acc_4_2 #(
   parameter int WIDTH           = 16,
   parameter int TRUNCATED_WIDTH = 16,
   parameter int N_TERMS         = 8,
   parameter int CNT_W           = $clog2(N_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode_shift,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_s,
   input  logic [WIDTH-1:0] x_c,
   input  logic             cin1,
   input  logic             cin2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ws,
   output logic [WIDTH-1:0] wc,
   output logic [CNT_W-1:0] term_cnt,
   output logic             busy
`ifdef CSA_ACC_RESOLVE_EN
   ,
   output logic [WIDTH-1:0] result
`endif
);

   localparam int LAST_INDEX = WIDTH - TRUNCATED_WIDTH;
   localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} << LAST_INDEX;
   localparam logic [WIDTH-1:0] CIN_BIT = WIDTH'(1) << LAST_INDEX;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

`ifdef CSA_ACC_RESOLVE_EN
   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, HOLD} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
`endif

   state_t state_q, state_d;
   logic   mode_q;
   logic   accept, last;

   logic [WIDTH-1:0] a, b, c, d;
   logic [WIDTH-1:0] s1, t1, s2, t2;

   assign accept = (state_q == ACCUM) & in_valid;
   assign last   = accept & (term_cnt == LAST_CNT);

   // Two full-adder levels; each level's carry lands one bit up, no ripple.
   always_comb begin
      a  = (mode_q ? (ws << 1) : ws) & MASK;
      b  = (mode_q ? (wc << 1) : wc) & MASK;
      c  = x_s & MASK;
      d  = x_c & MASK;
      s1 = a ^ b ^ c;
      t1 = (((a & b) | (a & c) | (b & c)) << 1) | (cin1 ? CIN_BIT : '0);
      t1 = t1 & MASK;
      s2 = (s1 ^ d ^ t1) & MASK;
      t2 = (((s1 & d) | (s1 & t1) | (d & t1)) << 1) | (cin2 ? CIN_BIT : '0);
      t2 = t2 & MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
`ifdef CSA_ACC_RESOLVE_EN
            ACCUM:   if (last) state_d = RESOLVE;
            RESOLVE: state_d = HOLD;
`else
            ACCUM:   if (last) state_d = HOLD;
`endif
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws       <= '0;
         wc       <= '0;
         term_cnt <= '0;
         mode_q   <= 1'b0;
      end else if (start) begin
         ws       <= '0;
         wc       <= '0;
         term_cnt <= '0;
         mode_q   <= mode_shift;
      end else if (accept) begin
         ws       <= s2;
         wc       <= t2;
         term_cnt <= term_cnt + CNT_W'(1);
      end
   end

`ifdef CSA_ACC_RESOLVE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  result <= '0;
      else if (start)              result <= '0;
      else if (state_q == RESOLVE) result <= ws + wc;
   end
`endif

endmodule

// File: tb/tb_csa_acc_4_2.sv
// Directed bench for csa_acc_4_2 with a value-level reference model.
// Two instances: full width N=4, and truncated (12 MSBs) N=2.
module tb_csa_acc_4_2;

   logic        clk = 0, rst_n = 0, start = 0, mode_shift = 0;
   logic        in_valid = 0, cin1 = 0, cin2 = 0, out_ready = 0;
   logic [15:0] x_s = 0, x_c = 0;

   logic [15:0] ws0, wc0, ws1, wc1;
   logic [2:0]  tc0;
   logic [1:0]  tc1;
   logic        ir0, ov0, bz0, ir1, ov1, bz1;
`ifdef CSA_ACC_RESOLVE_EN
   logic [15:0] res0, res1;
`endif

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   csa_acc_4_2 #(.WIDTH(16), .TRUNCATED_WIDTH(16), .N_TERMS(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_shift(mode_shift),
      .in_valid(in_valid), .in_ready(ir0), .x_s(x_s), .x_c(x_c),
      .cin1(cin1), .cin2(cin2), .out_valid(ov0), .out_ready(out_ready),
      .ws(ws0), .wc(wc0), .term_cnt(tc0), .busy(bz0)
`ifdef CSA_ACC_RESOLVE_EN
      , .result(res0)
`endif
   );

   csa_acc_4_2 #(.WIDTH(16), .TRUNCATED_WIDTH(12), .N_TERMS(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_shift(mode_shift),
      .in_valid(in_valid), .in_ready(ir1), .x_s(x_s), .x_c(x_c),
      .cin1(cin1), .cin2(cin2), .out_valid(ov1), .out_ready(out_ready),
      .ws(ws1), .wc(wc1), .term_cnt(tc1), .busy(bz1)
`ifdef CSA_ACC_RESOLVE_EN
      , .result(res1)
`endif
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference model: accumulated value as a plain integer per instance.
   bit [15:0] m_acc[2];
   int        m_cnt[2];
   bit        m_run[2], m_res[2], m_hold[2], m_mode[2];
   bit [15:0] p_ws[2];
   bit        p_hold[2];

   function automatic int nt(int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic int li(int i);
      return (i == 0) ? 0 : 4;
   endfunction

   function automatic bit [15:0] nxt_acc(int i);
      int        v;
      bit [15:0] mask;
      mask = 16'hFFFF << li(i);
      v = (m_mode[i] ? 2 : 1) * int'(m_acc[i]) + int'(x_s & mask)
          + int'(x_c & mask) + ((int'(cin1) + int'(cin2)) << li(i));
      return v[15:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_acc[i] <= 0; m_cnt[i] <= 0; m_run[i] <= 0;
            m_res[i] <= 0; m_hold[i] <= 0; m_mode[i] <= 0;
         end else if (start) begin
            m_acc[i] <= 0; m_cnt[i] <= 0; m_run[i] <= 1;
            m_res[i] <= 0; m_hold[i] <= 0; m_mode[i] <= mode_shift;
         end else if (m_run[i] && in_valid) begin
            m_acc[i] <= nxt_acc(i);
            m_cnt[i] <= m_cnt[i] + 1;
            if (m_cnt[i] == nt(i) - 1) begin
               m_run[i] <= 0;
`ifdef CSA_ACC_RESOLVE_EN
               m_res[i] <= 1;
`else
               m_hold[i] <= 1;
`endif
            end
         end else if (m_res[i]) begin
            m_res[i]  <= 0;
            m_hold[i] <= 1;
         end else if (m_hold[i] && out_ready) begin
            m_hold[i] <= 0;
         end
      end
   end

   task automatic cmp(int i, logic [15:0] ws, logic [15:0] wc,
                      logic [2:0] tc, logic ir, logic ov, logic bz,
                      logic [15:0] res);
      bit [15:0] lo;
      lo = ~(16'hFFFF << li(i));
      chk($sformatf("u%0d_value", i), 16'(ws + wc), m_acc[i]);
      chk($sformatf("u%0d_term_cnt", i), tc, m_cnt[i]);
      chk($sformatf("u%0d_in_ready", i), ir, m_run[i]);
      chk($sformatf("u%0d_out_valid", i), ov, m_hold[i]);
      chk($sformatf("u%0d_busy", i), bz, m_run[i] | m_res[i] | m_hold[i]);
      chk($sformatf("u%0d_low_bits", i), (ws | wc) & lo, 0);
      if (m_hold[i] && p_hold[i])
         chk($sformatf("u%0d_hold_stable", i), ws, p_ws[i]);
`ifdef CSA_ACC_RESOLVE_EN
      if (m_hold[i]) chk($sformatf("u%0d_result", i), res, m_acc[i]);
`else
      if (res != 0) chk("unused_res", res, 0);
`endif
   endtask

   always @(negedge clk) begin
`ifdef CSA_ACC_RESOLVE_EN
      cmp(0, ws0, wc0, tc0, ir0, ov0, bz0, res0);
      cmp(1, ws1, wc1, {1'b0, tc1}, ir1, ov1, bz1, res1);
`else
      cmp(0, ws0, wc0, tc0, ir0, ov0, bz0, 16'h0);
      cmp(1, ws1, wc1, {1'b0, tc1}, ir1, ov1, bz1, 16'h0);
`endif
      p_ws[0] <= ws0; p_ws[1] <= ws1;
      p_hold[0] <= m_hold[0]; p_hold[1] <= m_hold[1];
   end

   task automatic drive(bit v, bit [15:0] xs, bit [15:0] xc, bit c1, bit c2);
      in_valid = v; x_s = xs; x_c = xc; cin1 = c1; cin2 = c2;
      @(negedge clk);
   endtask

   task automatic do_start(bit m);
      start = 1; mode_shift = m; in_valid = 0;
      @(negedge clk);
      start = 0;
   endtask

   task automatic finish_op(string nm, bit [15:0] exp);
      in_valid = 0; cin1 = 0; cin2 = 0;
`ifdef CSA_ACC_RESOLVE_EN
      chk({nm, "_lat_pre"}, ov0, 0);
      @(negedge clk);
`endif
      chk({nm, "_lat"}, ov0, 1);
      chk({nm, "_val"}, 16'(ws0 + wc0), exp);
      chk({nm, "_cnt"}, tc0, 4);
`ifdef CSA_ACC_RESOLVE_EN
      chk({nm, "_result"}, res0, exp);
`endif
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({nm, "_idle"}, bz0, 0);
      chk({nm, "_retain"}, 16'(ws0 + wc0), exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit        pat[7];
      bit [15:0] w;
      pat = '{1, 0, 0, 1, 1, 0, 1};

      @(negedge clk);
      chk("rst_ws", ws0, 0); chk("rst_wc", wc0, 0); chk("rst_cnt", tc0, 0);
      chk("rst_ir", ir0, 0); chk("rst_ov", ov0, 0); chk("rst_busy", bz0, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      do_start(0);
      repeat (4) drive(1, 16'd1, 16'd2, 0, 0);
      finish_op("plain", 16'd12);

      do_start(1);
      repeat (4) drive(1, 16'd1, 16'd0, 0, 0);
      finish_op("shift", 16'd15);

      do_start(1);
      repeat (4) drive(1, 16'd1, 16'd0, 1, 1);
      finish_op("shift_cin", 16'd45);

      do_start(0);
      drive(1, 16'hFFFF, 16'h0001, 0, 0);
      drive(1, 16'h8000, 16'h8000, 0, 0);
      repeat (2) drive(1, 16'h0, 16'h0, 0, 0);
      finish_op("wrap", 16'h0000);

      do_start(0);
      drive(1, 16'h00FF, 16'h0, 1, 0);
      drive(1, 16'h0, 16'h0, 0, 0);
      in_valid = 0; cin1 = 0;
      @(negedge clk);
      @(negedge clk);
      chk("trunc_ov", ov1, 1);
      chk("trunc_val", 16'(ws1 + wc1), 16'h0100);
      chk("trunc_low", (ws1 | wc1) & 16'h000F, 0);
      repeat (2) drive(1, 16'h0, 16'h0, 0, 0);
      finish_op("trunc_u0", 16'h0100);

      do_start(0);
      foreach (pat[k]) drive(pat[k], 16'd1, 16'd0, 0, 0);
      in_valid = 0;
`ifdef CSA_ACC_RESOLVE_EN
      @(negedge clk);
`endif
      chk("hs_ov", ov0, 1);
      chk("hs_val", 16'(ws0 + wc0), 16'd4);
      chk("hs_cnt", tc0, 4);
      w = ws0;
      repeat (3) @(negedge clk);
      chk("hs_wait_ov", ov0, 1);
      chk("hs_wait_ws", ws0, w);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("hs_idle", bz0, 0);
      chk("hs_retain", 16'(ws0 + wc0), 16'd4);

      start = 1; in_valid = 1; x_s = 16'd5; x_c = 16'd0;
      @(negedge clk);
      start = 0; in_valid = 0;
      chk("start_beat_cnt", tc0, 0);
      chk("start_beat_val", 16'(ws0 + wc0), 0);
      chk("start_beat_ir", ir0, 1);

      repeat (2) drive(1, 16'd7, 16'd1, 0, 0);
      in_valid = 0;
      chk("mid_cnt", tc0, 2);
      #2 rst_n = 0;
      #1;
      chk("arst_ws", ws0, 0); chk("arst_wc", wc0, 0);
      chk("arst_cnt", tc0, 0); chk("arst_busy", bz0, 0);
      chk("arst_ir", ir0, 0); chk("arst_u1_cnt", tc1, 0);
      @(negedge clk);
      #2 rst_n = 1;
      @(negedge clk);

      do_start(0);
      repeat (4) drive(1, 16'd3, 16'd4, 0, 0);
      in_valid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("hold_ov", ov0, 1);
      chk("hold_val", 16'(ws0 + wc0), 16'd28);
      out_ready = 1;
      do_start(0);
      out_ready = 0;
      chk("restart_cnt", tc0, 0);
      chk("restart_ws", ws0, 0);
      chk("restart_wc", wc0, 0);
      chk("restart_ir", ir0, 1);
      repeat (4) drive(1, 16'd2, 16'd0, 0, 0);
      finish_op("restart", 16'd8);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
